muldiv_ctrl: RTL

- Sequencer for the HI/LO multiply/divide resource used by MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.
- Sits beside the EX stage and owns the architectural HI and LO registers.
- Runs multi-cycle multiplies and a 32-iteration radix-2 restoring divide.
- Stalls the pipeline while an operation is in flight and abandons it on an exception flush.

---
 rtl/muldiv_ctrl_if.sv | 26 ++
 rtl/muldiv_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl_if.sv
// HI/LO multiply/divide sequencer bus: EX-side request, MTHI/MTLO writes,
// flush, and the stall/done/busy/HI/LO results.
interface muldiv_ctrl_if;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic [1:0]  whilo_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start_i, op_i, src_a_i, src_b_i, whilo_i, wdata_i, flush_i,
        input  stall_o, done_o, busy_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, src_a_i, src_b_i, whilo_i, wdata_i, flush_i,
        output stall_o, done_o, busy_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO owner: multi-cycle MULT/MULTU, 32-step restoring DIV/DIVU, MTHI/MTLO.
// Optional macro MULDIV_EARLY_OUT_EN skips the iterations when |a| < |b|.
module muldiv_ctrl #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_SIGN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        busy_q;

    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [63:0] ext_a_s;
    logic [63:0] ext_b_s;
    logic [63:0] prod_s;
    logic [32:0] rem_sh_s;
    logic        fits_s;
    logic [31:0] rem_step_s;
    logic [31:0] quot_step_s;
    logic        div_signed_s;
    logic [31:0] quot_fix_s;
    logic [31:0] rem_fix_s;

    // Operand magnitudes are only negated for signed DIV (op[0]==0)
    assign mag_a_s = (!bus.op_i[0] && bus.src_a_i[31]) ? (32'd0 - bus.src_a_i) : bus.src_a_i;
    assign mag_b_s = (!bus.op_i[0] && bus.src_b_i[31]) ? (32'd0 - bus.src_b_i) : bus.src_b_i;

    // Sign- or zero-extend to 64 bits so one multiplier serves MULT and MULTU
    assign ext_a_s = {{32{a_q[31] & ~op_q[0]}}, a_q};
    assign ext_b_s = {{32{b_q[31] & ~op_q[0]}}, b_q};
    assign prod_s  = ext_a_s * ext_b_s;

    assign rem_sh_s    = {rem_q, quot_q[31]};
    assign fits_s      = (rem_sh_s >= {1'b0, dvs_q});
    assign rem_step_s  = fits_s ? 32'(rem_sh_s - {1'b0, dvs_q}) : rem_sh_s[31:0];
    assign quot_step_s = {quot_q[30:0], fits_s};

    assign div_signed_s = ~op_q[0];
    assign quot_fix_s   = (div_signed_s && (a_q[31] ^ b_q[31])) ? (32'd0 - quot_q) : quot_q;
    assign rem_fix_s    = (div_signed_s && a_q[31]) ? (32'd0 - rem_q) : rem_q;

    assign bus.stall_o = (bus.start_i && (state_q == S_IDLE) && !bus.flush_i) ||
                         (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_SIGN);
    assign bus.done_o  = done_q;
    assign bus.busy_o  = busy_q;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;

    // Next-state, datapath and HI/LO commit logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.flush_i) begin
                    cnt_d = 5'd0;
                end else if (bus.whilo_i != 2'b00) begin
                    hi_d = bus.whilo_i[1] ? bus.wdata_i : hi_q;
                    lo_d = bus.whilo_i[0] ? bus.wdata_i : lo_q;
                end else if (bus.start_i) begin
                    op_d = bus.op_i;
                    a_d  = bus.src_a_i;
                    b_d  = bus.src_b_i;
                    if (!bus.op_i[1]) begin
                        state_d = S_MUL;
                        cnt_d   = 5'(MUL_LAT - 1);
                    end else begin
                        state_d = S_DIV;
                        dvs_d   = mag_b_s;
                        quot_d  = mag_a_s;
                        rem_d   = 32'd0;
                        cnt_d   = 5'(DIV_ITER - 1);
`ifdef MULDIV_EARLY_OUT_EN
                        if ((mag_b_s != 32'd0) && (mag_a_s < mag_b_s)) begin
                            state_d = S_SIGN;
                            quot_d  = 32'd0;
                            rem_d   = mag_a_s;
                            cnt_d   = 5'd0;
                        end else begin
                            state_d = S_DIV;
                        end
`endif
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else if (cnt_q == 5'd0) begin
                    hi_d    = prod_s[63:32];
                    lo_d    = prod_s[31:0];
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_DIV: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    rem_d  = rem_step_s;
                    quot_d = quot_step_s;
                    if (cnt_q == 5'd0) begin
                        state_d = S_SIGN;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            S_SIGN: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else if (b_q == 32'd0) begin
                    // Divide by zero: fixed result independent of signs
                    hi_d    = a_q;
                    lo_d    = 32'hFFFF_FFFF;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    hi_d    = rem_fix_s;
                    lo_d    = quot_fix_s;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            dvs_q   <= 32'd0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

endmodule
